// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// the long-instruction marker bit and the instruction-length helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_ARG  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned LONG_BIT_POS = 7;

  function automatic logic [1:0] instr_len(input logic is_long);
    return is_long ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fetch_next_addr.sv
// Combinational next-PC selection: reset, branch redirect, advance past a
// consumed instruction, or hold.
module fetch_next_addr
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              consume,
  input  logic              is_long,
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic [ADDR_W-1:0] current_address,
  output logic [ADDR_W-1:0] next_address
);

  always_comb begin
    next_address = current_address;
    if (reset)
      next_address = '0;
    else if (redirect_valid)
      next_address = redirect_addr;
    else if (consume)
      next_address = instr_pc + ADDR_W'(instr_len(is_long));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode/operand bytes over a req/ack memory
// port, presents them to execute with valid/ready and steers the PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LONG_BIT = LONG_BIT_POS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current_address,
  output logic [ADDR_W-1:0] next_address,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_op,
  output logic [DATA_W-1:0] instr_arg,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
);

  fetch_state_t state;
  logic         kill;
  logic         flush;

  // A redirect arriving together with the ack discards that byte too.
  assign flush = kill | redirect_valid;

  fetch_next_addr #(
    .ADDR_W(ADDR_W)
  ) u_next_addr (
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .consume        (instr_valid & instr_ready),
    .is_long        (instr_op[LONG_BIT]),
    .instr_pc       (instr_pc),
    .current_address(current_address),
    .next_address   (next_address)
  );

  // mem_addr is captured from next_address, i.e. the value the PC loads on
  // the same edge, so it stays stable even if the PC is redirected later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_OP;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_op    <= '0;
      instr_arg   <= '0;
      instr_pc    <= '0;
      kill        <= 1'b0;
    end else begin
      unique case (state)
        S_OP: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= next_address;
          end else if (mem_ack) begin
            if (flush) begin
              kill     <= 1'b0;
              mem_addr <= next_address;
            end else begin
              instr_op <= mem_rdata;
              instr_pc <= mem_addr;
              if (mem_rdata[LONG_BIT]) begin
                state    <= S_ARG;
                mem_addr <= mem_addr + 1'b1;
              end else begin
                instr_arg   <= '0;
                state       <= S_HOLD;
                instr_valid <= 1'b1;
                mem_req     <= 1'b0;
              end
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        S_ARG: begin
          if (mem_ack) begin
            if (flush) begin
              kill     <= 1'b0;
              state    <= S_OP;
              mem_addr <= next_address;
            end else begin
              instr_arg   <= mem_rdata;
              state       <= S_HOLD;
              instr_valid <= 1'b1;
              mem_req     <= 1'b0;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || instr_ready) begin
            state       <= S_OP;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= next_address;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register model and a small
// req/ack memory whose response delay can be stretched per step.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] current_address;
  logic [7:0] next_address;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready = 1'b1;
  logic [7:0] instr_op;
  logic [7:0] instr_arg;
  logic [7:0] instr_pc;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = 8'h00;

  logic [7:0] mem [256];
  int         lat_extra = 0;
  int         wait_cnt  = 0;
  logic       req_prev  = 1'b0;
  logic [7:0] ack_log [$];
  int         n_checks  = 0;
  int         n_fail    = 0;

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .LONG_BIT(7)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .current_address(current_address),
    .next_address   (next_address),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_arg      (instr_arg),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  always @(posedge clock) current_address <= next_address;

  // Never acks in the cycle a request first rises; lat_extra adds wait cycles.
  assign mem_ack   = mem_req && req_prev && (wait_cnt >= lat_extra);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    req_prev <= mem_req;
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (mem_req && mem_ack) ack_log.push_back(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic check_instr(input string tag, input logic [7:0] op, input logic [7:0] arg,
                             input logic [7:0] pc);
    check({tag, "_op"},  32'(instr_op),  32'(op));
    check({tag, "_arg"}, 32'(instr_arg), 32'(arg));
    check({tag, "_pc"},  32'(instr_pc),  32'(pc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h05;
    mem[8'h10] = 8'h83;
    mem[8'h11] = 8'h44;
    mem[8'h12] = 8'h21;
    mem[8'h40] = 8'h07;
    mem[8'hFF] = 8'h9A;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_req",   32'(mem_req),         32'd0);
    check("rst_valid", 32'(instr_valid),     32'd0);
    check_instr("rst", 8'h00, 8'h00, 8'h00);
    check("rst_next",  32'(next_address),    32'd0);
    check("rst_pc",    32'(current_address), 32'd0);

    // 1-byte instruction at 0x00 with ready high
    reset = 1'b0;
    wait_valid("t1");
    check_instr("t1", 8'h05, 8'h00, 8'h00);
    check("t1_next", 32'(next_address), 32'h01);

    // Redirect to 0x10 while the fetch at 0x01 is outstanding
    @(negedge clock);
    instr_ready = 1'b0;
    check("t2_req0",  32'(mem_req),  32'd1);
    check("t2_addr0", 32'(mem_addr), 32'h01);
    ack_log.delete();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h10;
    #1 check("t2_next_redir", 32'(next_address), 32'h10);
    @(negedge clock);
    redirect_valid = 1'b0;
    check("t2_req_held",  32'(mem_req),         32'd1);
    check("t2_addr_held", 32'(mem_addr),        32'h01);
    check("t2_pc",        32'(current_address), 32'h10);
    wait_valid("t2");
    check_instr("t2", 8'h83, 8'h44, 8'h10);
    check("t2_next", 32'(next_address), 32'h10);
    check("t2_log_n", 32'(ack_log.size()), 32'd3);
    if (ack_log.size() == 3) begin
      check("t2_log0", 32'(ack_log[0]), 32'h01);
      check("t2_log1", 32'(ack_log[1]), 32'h10);
      check("t2_log2", 32'(ack_log[2]), 32'h11);
    end

    // Back-pressure in S_HOLD
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("t3_valid", 32'(instr_valid),  32'd1);
      check_instr("t3", 8'h83, 8'h44, 8'h10);
      check("t3_req",   32'(mem_req),      32'd0);
      check("t3_next",  32'(next_address), 32'h10);
    end

    // Consume the 2-byte instruction, then 1-byte latency at 0x12
    instr_ready = 1'b1;
    #1 check("t3_next_adv", 32'(next_address), 32'h12);
    @(negedge clock);
    instr_ready = 1'b0;
    check("lat1_c0_valid", 32'(instr_valid), 32'd0);
    check("lat1_c0_addr",  32'(mem_addr),    32'h12);
    check("lat1_c0_req",   32'(mem_req),     32'd1);
    @(negedge clock);
    check("lat1_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clock);
    check("lat1_c2_valid", 32'(instr_valid), 32'd1);
    check_instr("lat1", 8'h21, 8'h00, 8'h12);

    // Redirect beats ready in S_HOLD; 2-byte op wrapping at 0xFF
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    instr_ready    = 1'b1;
    #1 check("t5_next_redir", 32'(next_address), 32'hFF);
    @(negedge clock);
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("t5_c0_valid", 32'(instr_valid),     32'd0);
    check("t5_c0_addr",  32'(mem_addr),        32'hFF);
    check("t5_c0_pc",    32'(current_address), 32'hFF);
    @(negedge clock);
    check("t5_c1_valid", 32'(instr_valid), 32'd0);
    check("t5_c1_addr",  32'(mem_addr),    32'hFF);
    @(negedge clock);
    check("t5_c2_valid", 32'(instr_valid), 32'd0);
    check("t5_c2_addr",  32'(mem_addr),    32'h00);
    @(negedge clock);
    check("t5_c3_valid", 32'(instr_valid), 32'd1);
    check_instr("t5", 8'h9A, 8'h05, 8'hFF);
    check("t5_next_hold", 32'(next_address), 32'hFF);
    instr_ready = 1'b1;
    #1 check("t5_next_wrap", 32'(next_address), 32'h01);

    // Slow memory: two redirects before the ack of the fetch at 0x01
    lat_extra = 3;
    @(negedge clock);
    instr_ready = 1'b0;
    ack_log.delete();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h20;
    check("t4_c0_req",  32'(mem_req),  32'd1);
    check("t4_c0_addr", 32'(mem_addr), 32'h01);
    @(negedge clock);
    redirect_addr = 8'h40;
    check("t4_c1_req",  32'(mem_req),         32'd1);
    check("t4_c1_addr", 32'(mem_addr),        32'h01);
    check("t4_c1_pc",   32'(current_address), 32'h20);
    @(negedge clock);
    redirect_valid = 1'b0;
    check("t4_c2_req",  32'(mem_req),         32'd1);
    check("t4_c2_addr", 32'(mem_addr),        32'h01);
    check("t4_c2_pc",   32'(current_address), 32'h40);
    wait_valid("t4");
    check_instr("t4", 8'h07, 8'h00, 8'h40);
    check("t4_log_n", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check("t4_log0", 32'(ack_log[0]), 32'h01);
      check("t4_log1", 32'(ack_log[1]), 32'h40);
    end
    lat_extra = 0;

    // Reset while the operand read is pending
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h10;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    lat_extra = 3;
    check("t6_arg_req",  32'(mem_req),  32'd1);
    check("t6_arg_addr", 32'(mem_addr), 32'h11);
    @(negedge clock);
    check("t6_pending",  32'(mem_req),  32'd1);
    reset     = 1'b1;
    lat_extra = 0;
    @(negedge clock);
    ack_log.delete();
    check("t6_rst_req",   32'(mem_req),      32'd0);
    check("t6_rst_valid", 32'(instr_valid),  32'd0);
    check("t6_rst_op",    32'(instr_op),     32'd0);
    check("t6_rst_next",  32'(next_address), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_valid("t6");
    check_instr("t6", 8'h05, 8'h00, 8'h00);
    check("t6_log_n", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) check("t6_log0", 32'(ack_log[0]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
